// File: rtl/int_mult_arbiter_if.sv
// Bundle between the requester lanes, the shared multiplier and the round-robin arbiter.
// The arbiter sits on the slave side. The lanes and the multiplier sit on the master side.
interface int_mult_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int WIDTHA = 17,
  parameter int WIDTHB = 17,
  parameter int DM     = 4
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(DM + 1);

  // Handshake rules:
  // - Requester i transfers an op in a cycle where req_valid[i] & req_ready[i] are both high.
  // - While req_valid[i] is high and no grant has arrived, requester i holds req_a/req_b stable.
  // - req_ready is one-hot or zero, and it is combinational.
  // - rsp_valid is a single-cycle pulse. It has no backpressure.
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*WIDTHA-1:0] req_a;
  logic [NREQ*WIDTHB-1:0] req_b;
  logic [NREQ-1:0]        req_ready;
  logic [WIDTHA-1:0]      mult_a;
  logic [WIDTHB-1:0]      mult_b;
  logic [WIDTHA+WIDTHB-1:0] mult_res;
  logic                   rsp_valid;
  logic [IDW-1:0]         rsp_id;
  logic [WIDTHA+WIDTHB-1:0] rsp_data;
  logic [CW-1:0]          inflight;
  logic [IDW-1:0]         rr_ptr;    // debug view of the rotation pointer

  modport slave (
    input  req_valid, req_a, req_b, mult_res,
    output req_ready, mult_a, mult_b, rsp_valid, rsp_id, rsp_data, inflight, rr_ptr
  );

  modport master (
    output req_valid, req_a, req_b, mult_res,
    input  req_ready, mult_a, mult_b, rsp_valid, rsp_id, rsp_data, inflight, rr_ptr
  );
endinterface

// File: rtl/int_mult_arbiter.sv
// Round-robin arbiter in front of one fixed-latency pipelined multiplier.
// A DM-deep valid/ID shadow pipeline tags each returning product with the ID of the requester that issued it.
module int_mult_arbiter #(
  parameter int NREQ   = 4,
  parameter int WIDTHA = 17,
  parameter int WIDTHB = 17,
  parameter int DM     = 4
) (
  input logic clk,
  input logic rst,
  int_mult_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(DM + 1);

  logic [IDW-1:0]  rr_ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;
  logic [DM-1:0]   vld;
  logic [IDW-1:0]  id_pipe [DM];
  logic [CW-1:0]   inflight;
  int              scan_idx;

  // Search upward from rr_ptr with wrap. Reset masks every grant.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan_idx  = 0;
    if (!rst) begin
      for (int k = 0; k < NREQ; k++) begin
        scan_idx = (int'(rr_ptr) + k) % NREQ;
        if (!grant_any && bus.req_valid[scan_idx]) begin
          grant_any          = 1'b1;
          grant[scan_idx]    = 1'b1;
          grant_idx          = IDW'(scan_idx);
        end
      end
    end
  end

  always_comb begin
    bus.mult_a = '0;
    bus.mult_b = '0;
    if (grant_any) begin
      bus.mult_a = bus.req_a[int'(grant_idx)*WIDTHA +: WIDTHA];
      bus.mult_b = bus.req_b[int'(grant_idx)*WIDTHB +: WIDTHB];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      vld      <= '0;
      inflight <= '0;
    end else begin
      if (grant_any)
        rr_ptr <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IDW'(1);
      vld <= {vld[DM-2:0], grant_any};
      case ({grant_any, vld[DM-1]})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // IDs are only meaningful where vld is set, so they need no reset.
  always_ff @(posedge clk) begin
    id_pipe[0] <= grant_idx;
    for (int k = 1; k < DM; k++)
      id_pipe[k] <= id_pipe[k-1];
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = vld[DM-1];
  assign bus.rsp_id    = id_pipe[DM-1];
  assign bus.rsp_data  = bus.mult_res;
  assign bus.inflight  = inflight;
  assign bus.rr_ptr    = rr_ptr;
endmodule

// File: tb/tb_int_mult_arbiter.sv
// Bench for int_mult_arbiter. It models the multiplier, runs directed scenarios and then random traffic.
// Results are checked against a rotation model and a scoreboard of returning products.
module tb_int_mult_arbiter;
  localparam int NREQ = 4;
  localparam int WA   = 17;
  localparam int WB   = 17;
  localparam int DM   = 4;
  localparam int IDW  = 2;
  localparam int RW   = WA + WB;

  typedef struct packed {
    logic [31:0]     due;
    logic [IDW-1:0]  id;
    logic [RW-1:0]   data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int_mult_arbiter_if #(.NREQ(NREQ), .WIDTHA(WA), .WIDTHB(WB), .DM(DM)) bus ();
  int_mult_arbiter #(.NREQ(NREQ), .WIDTHA(WA), .WIDTHB(WB), .DM(DM)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Shared multiplier: fixed latency DM, no stall, no reset
  logic [RW-1:0] mpipe [DM];
  always_ff @(posedge clk) begin
    mpipe[0] <= RW'(bus.mult_a) * RW'(bus.mult_b);
    for (int k = 1; k < DM; k++) mpipe[k] <= mpipe[k-1];
  end
  assign bus.mult_res = mpipe[DM-1];

  // Requester state and reference model
  logic          v    [NREQ];
  logic [WA-1:0] a_op [NREQ];
  logic [WB-1:0] b_op [NREQ];
  exp_t exp_q [$];
  int   grant_log [$];
  int   cyc, m_ptr, checks, failures;
  int   rsp_seen, max_inflight, last_rsp_cyc;
  logic [RW-1:0]  last_rsp_data;
  logic [IDW-1:0] last_rsp_id;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]          = v[i];
      bus.req_a[i*WA +: WA]     = a_op[i];
      bus.req_b[i*WB +: WB]     = b_op[i];
    end
  endtask

  task automatic load(input int i, input logic [WA-1:0] a, input logic [WB-1:0] b);
    v[i] = 1'b1; a_op[i] = a; b_op[i] = b;
  endtask

  // One clock cycle: drive inputs, check at the negedge, update the model, move past the posedge
  task automatic step();
    int win;
    int idx;
    logic [NREQ-1:0] exp_ready;
    logic [WA-1:0]   exp_ma;
    logic [WB-1:0]   exp_mb;
    drive();
    @(negedge clk);
    win = -1;
    if (!rst)
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (win < 0 && v[idx]) win = idx;
      end
    exp_ready = '0;
    exp_ma = '0;
    exp_mb = '0;
    if (win >= 0) begin
      exp_ready[win] = 1'b1;
      exp_ma = a_op[win];
      exp_mb = b_op[win];
    end
    chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    chk("mult_a", 64'(bus.mult_a), 64'(exp_ma));
    chk("mult_b", 64'(bus.mult_b), 64'(exp_mb));
    chk("inflight", 64'(bus.inflight), 64'(exp_q.size()));
    if (int'(bus.inflight) > max_inflight) max_inflight = int'(bus.inflight);
    if (bus.rsp_valid === 1'b1) begin
      rsp_seen++;
      last_rsp_cyc  = cyc;
      last_rsp_data = bus.rsp_data;
      last_rsp_id   = bus.rsp_id;
    end
    if (exp_q.size() > 0 && int'(exp_q[0].due) == cyc) begin
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(1));
      chk("rsp_id", 64'(bus.rsp_id), 64'(exp_q[0].id));
      chk("rsp_data", 64'(bus.rsp_data), 64'(exp_q[0].data));
      void'(exp_q.pop_front());
    end else begin
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(0));
    end
    if (rst) begin
      exp_q.delete();
      m_ptr = 0;
    end else if (win >= 0) begin
      exp_q.push_back('{due: 32'(cyc + DM), id: IDW'(win),
                        data: RW'(a_op[win]) * RW'(b_op[win])});
      m_ptr = (win + 1) % NREQ;
      grant_log.push_back(win);
      v[win] = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int t0;
    checks = 0; failures = 0; cyc = 0; m_ptr = 0;
    rsp_seen = 0; max_inflight = 0; last_rsp_cyc = -1;
    last_rsp_data = '0; last_rsp_id = '0;
    for (int i = 0; i < NREQ; i++) begin v[i] = 1'b0; a_op[i] = '0; b_op[i] = '0; end
    drive();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;

    // Single op and its latency
    load(1, 17'd3, 17'd5);
    t0 = cyc;
    step();
    chk("t2_grant", 64'(grant_log[$]), 64'(1));
    idle(5);
    chk("t2_rsp_cyc", 64'(last_rsp_cyc), 64'(t0 + 4));
    chk("t2_rsp_data", 64'(last_rsp_data), 64'(15));
    chk("t2_rsp_id", 64'(last_rsp_id), 64'(1));

    // Full load from reset
    rst = 1'b1; step(); rst = 1'b0;
    grant_log.delete();
    max_inflight = 0;
    for (int i = 0; i < NREQ; i++) load(i, WA'($urandom), WB'($urandom));
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!v[i]) load(i, WA'($urandom), WB'($urandom));
      step();
    end
    idle(DM + 1);
    for (int n = 0; n < 8; n++) chk("t3_grant_order", 64'(grant_log[n]), 64'(n % NREQ));
    chk("t3_inflight_max", 64'(max_inflight), 64'(DM));

    // Rotation with gaps: move the pointer to 2, then offer 0011
    load(1, 17'd7, 17'd9);
    step();
    chk("t4_ptr2", 64'(bus.rr_ptr), 64'(2));
    grant_log.delete();
    load(0, 17'd11, 17'd13);
    load(1, 17'd17, 17'd19);
    step();
    chk("t4_ptr1", 64'(bus.rr_ptr), 64'(1));
    load(0, 17'd11, 17'd13);
    step();
    chk("t4_first", 64'(grant_log[0]), 64'(0));
    chk("t4_second", 64'(grant_log[1]), 64'(1));
    idle(DM + 2);

    // Max operands
    load(2, 17'h1FFFF, 17'h1FFFF);
    step();
    idle(DM + 1);
    chk("t5_max_product", 64'(last_rsp_data), 64'(34'h3_FFFC_0001));

    // Back-to-back issue with a response in the same cycle
    for (int n = 0; n < 12; n++) begin
      load(3, WA'($urandom), WB'($urandom));
      step();
      if (n >= DM - 1) chk("t6_inflight_const", 64'(bus.inflight), 64'(DM));
    end
    idle(DM + 1);

    // Reset drain: rst arrives in the cycle after the third grant
    load(0, 17'd21, 17'd22);
    load(1, 17'd23, 17'd24);
    load(2, 17'd25, 17'd26);
    step(); step(); step();
    for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    chk("t1_inflight_after_rst", 64'(bus.inflight), 64'(0));
    rsp_seen = 0;
    idle(2 * DM);
    chk("t1_no_rsp_after_rst", 64'(rsp_seen), 64'(0));

    // Random traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!v[i] && $urandom_range(0, 1) == 1) load(i, WA'($urandom), WB'($urandom));
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    idle(DM + 2);
    chk("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
